// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard inputs and stage-control outputs between the pipeline and pipe_stall_ctrl.
interface pipe_stall_ctrl_if #(parameter int CNT_W = 16);
    logic [2:0]       id_rs;
    logic [2:0]       id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             ex_memRead;
    logic [2:0]       ex_regWriteNum;
    logic             br_taken;
    logic             imem_stall;
    logic             dmem_stall;
    logic             dmem_done;
    logic             halt_wb;
    logic             en_pc;
    logic             en_ifid;
    logic             en_idex;
    logic             en_exmem;
    logic             en_memwb;
    logic             flush_ifid;
    logic             nop_idex;
    logic             nop_memwb;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, ex_memRead, ex_regWriteNum,
               br_taken, imem_stall, dmem_stall, dmem_done, halt_wb,
        input  en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, nop_idex,
               nop_memwb, halted, err, stall_cnt
    );
    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, ex_memRead, ex_regWriteNum,
               br_taken, imem_stall, dmem_stall, dmem_done, halt_wb,
        output en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, nop_idex,
               nop_memwb, halted, err, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush sequencer for the 5-stage pipeline.
// STALL_PERF_EN enables the stall_cnt performance counter; otherwise it reads 0.
module pipe_stall_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;
    state_t     state;
    logic [6:0] wcnt;
    logic       err_q;
    logic       run, wt, act, hlt_c, dst, br, lu, im, ld_use;
    assign ld_use = bus.ex_memRead &
                    ((bus.id_rs_used & (bus.id_rs == bus.ex_regWriteNum)) |
                     (bus.id_rt_used & (bus.id_rt == bus.ex_regWriteNum)));
    // Priority chain inside RUN; MEM_WAIT holds the dmem freeze until done.
    assign run   = (state == RUN) & ~bus.halt_wb;
    assign wt    = state == MEM_WAIT;
    assign act   = ~rst & (state != HALT);
    assign hlt_c = (state == RUN) & bus.halt_wb;
    assign dst   = (run & bus.dmem_stall & ~bus.dmem_done) | (wt & ~bus.dmem_done);
    assign br    = run & ~dst & bus.br_taken;
    assign lu    = run & ~dst & ~bus.br_taken & ld_use;
    assign im    = run & ~dst & ~bus.br_taken & ~ld_use & bus.imem_stall;
    assign bus.en_pc      = act & ~hlt_c & ~dst & ~lu & ~im;
    assign bus.en_ifid    = act & ~hlt_c & ~dst & ~lu;
    assign bus.en_idex    = act & ~hlt_c & ~dst;
    assign bus.en_exmem   = act & ~hlt_c & ~dst;
    assign bus.en_memwb   = act;
    assign bus.flush_ifid = act & (br | im);
    assign bus.nop_idex   = act & (br | lu);
    assign bus.nop_memwb  = act & dst;
    assign bus.halted     = state == HALT;
    assign bus.err        = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            wcnt  <= '0;
            err_q <= 1'b0;
        end else if (state == RUN) begin
            if (bus.halt_wb) begin
                state <= HALT;
            end else if (bus.dmem_stall & ~bus.dmem_done) begin
                state <= MEM_WAIT;
                wcnt  <= 7'd1;
            end
        end else if (state == MEM_WAIT) begin
            wcnt <= wcnt + 7'd1;
            if (bus.dmem_done) begin
                state <= RUN;
            end else if (wcnt == 7'(MAX_WAIT - 1)) begin
                err_q <= 1'b1;
                state <= HALT;
            end
        end
    end
`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (~bus.en_pc & (state != HALT) & ~(&cnt))
            cnt <= cnt + 1'b1;
    end
    assign bus.stall_cnt = cnt;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: table-driven and sequence checks of pipe_stall_ctrl with an expected-output queue.
module tb_pipe_stall_ctrl;
    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       rs_u;
        logic       rt_u;
        logic       mrd;
        logic [2:0] wn;
        logic       br;
        logic       im;
        logic       ds;
        logic       dd;
        logic       hw;
    } in_t;
    typedef struct {
        in_t        i;
        logic [7:0] e;
    } vec_t;
    // Output order: en_pc en_ifid en_idex en_exmem en_memwb flush_ifid nop_idex nop_memwb
    localparam logic [7:0] NORM = 8'b11111_000;
    localparam logic [7:0] LU   = 8'b00111_010;
    localparam logic [7:0] BR   = 8'b11111_110;
    localparam logic [7:0] IM   = 8'b01111_100;
    localparam logic [7:0] DST  = 8'b00001_001;
    localparam logic [7:0] HW   = 8'b00001_000;
    localparam logic [7:0] ZERO = 8'b00000_000;
`ifdef STALL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    string      nm_q[$];
    logic [7:0] outs;
    vec_t       vt[10];
    in_t        idle;
    pipe_stall_ctrl_if #(.CNT_W(16)) b();
    pipe_stall_ctrl #(.MAX_WAIT(64), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(b));
    always #5 clk = ~clk;
    assign outs = {b.en_pc, b.en_ifid, b.en_idex, b.en_exmem, b.en_memwb,
                   b.flush_ifid, b.nop_idex, b.nop_memwb};
    task automatic drive(input in_t v);
        b.id_rs = v.rs;
        b.id_rt = v.rt;
        b.id_rs_used = v.rs_u;
        b.id_rt_used = v.rt_u;
        b.ex_memRead = v.mrd;
        b.ex_regWriteNum = v.wn;
        b.br_taken = v.br;
        b.imem_stall = v.im;
        b.dmem_stall = v.ds;
        b.dmem_done = v.dd;
        b.halt_wb = v.hw;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic step(input in_t v, input logic [7:0] e, input string nm);
        drive(v);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        chk(nm_q.pop_front(), 32'(outs), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        drive(idle);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[0] = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, NORM};
        vt[1] = '{'{3, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0}, LU};
        vt[2] = '{'{3, 5, 0, 1, 1, 3, 0, 0, 0, 0, 0}, NORM};
        vt[3] = '{'{1, 6, 1, 1, 1, 6, 0, 0, 0, 0, 0}, LU};
        vt[4] = '{'{0, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0}, LU};
        vt[5] = '{'{4, 4, 1, 1, 0, 4, 0, 0, 0, 0, 0}, NORM};
        vt[6] = '{'{3, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0}, BR};
        vt[7] = '{'{0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0}, IM};
        vt[8] = '{'{2, 0, 1, 0, 1, 2, 0, 1, 0, 0, 0}, LU};
        vt[9] = '{'{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0}, BR};
        drive(idle);
        #1;
        chk("rst_outs", 32'(outs), 32'(ZERO));
        chk("rst_halted", 32'(b.halted), 0);
        chk("rst_err", 32'(b.err), 0);
        chk("rst_cnt", 32'(b.stall_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 10; k++)
            step(vt[k].i, vt[k].e, $sformatf("vec%0d", k));
        // dmem wait of three cycles (imem also stalled on entry), then done with a branch
        do_reset();
        step('{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0}, DST, "dmem_c1");
        step('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}, DST, "dmem_c2");
        step('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}, DST, "dmem_c3");
        step('{0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0}, NORM, "dmem_done");
        step('{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0}, BR, "dmem_br_late");
        chk("dmem_cnt", 32'(b.stall_cnt), PERF ? 3 : 0);
        // data-memory timeout
        do_reset();
        for (int k = 0; k < 64; k++)
            step('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}, DST, $sformatf("tmo_c%0d", k));
        chk("tmo_err", 32'(b.err), 1);
        chk("tmo_halted", 32'(b.halted), 1);
        step('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}, ZERO, "tmo_ignored");
        chk("tmo_cnt", 32'(b.stall_cnt), PERF ? 64 : 0);
        rst = 1'b1;
        #1;
        chk("tmo_rst_err", 32'(b.err), 0);
        chk("tmo_rst_halted", 32'(b.halted), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // halt drain, stickiness, asynchronous reset out of HALT
        step('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, HW, "halt_c0");
        chk("halt_flag", 32'(b.halted), 1);
        step('{3, 0, 1, 0, 1, 3, 1, 1, 0, 0, 0}, ZERO, "halt_c1");
        step('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1}, ZERO, "halt_c2");
        chk("halt_sticky", 32'(b.halted), 1);
        chk("halt_cnt", 32'(b.stall_cnt), PERF ? 1 : 0);
        drive(idle);
        #2;
        rst = 1'b1;
        #1;
        chk("halt_async_halted", 32'(b.halted), 0);
        chk("halt_async_outs", 32'(outs), 32'(ZERO));
        chk("halt_async_cnt", 32'(b.stall_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(idle, NORM, "after_halt_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable, plus bubble/flush controls.
- Resolves load-use hazards, taken-branch/jump redirects, instruction- and data-memory stalls, and halt drain.
- The EX/MEM register's `en` and nop inputs are driven exclusively from here.

Parameters:
- MAX_WAIT, 64: maximum consecutive data-memory stall cycles before a fatal error.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- id_rs  in  3  source reg 1 of the instruction in ID
- id_rt  in  3  source reg 2 of the instruction in ID
- id_rs_used  in  1  id_rs is actually read
- id_rt_used  in  1  id_rt is actually read
- ex_memRead  in  1  instruction in EX is a load
- ex_regWriteNum  in  3  destination register of the instruction in EX
- br_taken  in  1  branch/jump resolved taken in EX this cycle
- imem_stall  in  1  instruction memory not ready
- dmem_stall  in  1  data memory busy on the MEM-stage access
- dmem_done  in  1  data memory access complete this cycle
- halt_wb  in  1  halt instruction has reached WB
- en_pc  out  1  PC register enable
- en_ifid  out  1  IF/ID enable
- en_idex  out  1  ID/EX enable
- en_exmem  out  1  EX/MEM enable
- en_memwb  out  1  MEM/WB enable
- flush_ifid  out  1  IF/ID loads a nop
- nop_idex  out  1  ID/EX loads a bubble (regWriteEnable, memWriteEnable, memReadEnable, halt cleared)
- nop_memwb  out  1  MEM/WB loads a bubble
- halted  out  1  processor halted (sticky)
- err  out  1  data-memory timeout (sticky)
- stall_cnt  out  CNT_W  total stall cycles

Behaviour:
- State register: RUN=0, MEM_WAIT=1, HALT=2 (2 bits). Wait counter: 7 bits, sized to MAX_WAIT.
- Outputs are combinational from the registered state and the current inputs.
- rst asserted:
  - state=RUN, wait counter=0, halted=0, err=0, stall_cnt=0.
  - All en_*, flush and nop outputs forced to 0.
- Priority within RUN, highest first: halt_wb > dmem_stall > br_taken > load-use > imem_stall > normal.
- Normal: all five enables =1; flush/nop outputs =0.
- halt_wb=1:
  - Next state HALT.
  - This cycle, MEM/WB still captures (en_memwb=1); all other enables =0.
- dmem_stall=1 and dmem_done=0:
  - Next state MEM_WAIT; wait counter <=1.
  - en_pc=en_ifid=en_idex=en_exmem=0.
  - en_memwb=1 with nop_memwb=1.
- br_taken=1:
  - All enables =1; flush_ifid=1 and nop_idex=1 for exactly this cycle.
  - Load-use detection is ignored this cycle, because the ID instruction is being squashed.
- Load-use condition: ex_memRead & ((id_rs_used & id_rs==ex_regWriteNum) | (id_rt_used & id_rt==ex_regWriteNum)).
  - R0 is a real register; there is no zero exemption.
  - Response: en_pc=0, en_ifid=0, en_idex=1 with nop_idex=1, en_exmem=en_memwb=1.
  - Exactly one bubble per hazard: on the next cycle the load has left EX, so the condition clears naturally.
- imem_stall=1 (and nothing of higher priority):
  - en_pc=0; en_ifid=1 with flush_ifid=1; downstream stages advance.
- MEM_WAIT:
  - Enables are the same as on stall entry.
  - Wait counter increments each cycle.
  - dmem_done=1 → RUN, and all enables =1 in that same cycle so the completed access advances.
  - If dmem_done=1 and br_taken=1 in the same cycle, the branch is honoured one cycle later: EX was frozen, so br_taken is re-presented by EX.
  - Counter reaching MAX_WAIT with no dmem_done → err=1, next state HALT.
- HALT:
  - All enables =0; halted=1.
  - Sticky until rst; all inputs are ignored.
- Simultaneous imem_stall and dmem_stall: the dmem rule wins, since the PC is already frozen.
- stall_cnt:
  - Increments in every cycle where en_pc=0 and the state is not HALT.
  - Saturates at all-ones.
  - Unaffected by the err transition.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined: stall_cnt is implemented as specified above.
- Undefined: the counter register is not instantiated and stall_cnt is tied to 0.

Test Plan:
- Load to R3 in EX (ex_memRead=1, ex_regWriteNum=3); ID has id_rs=3, id_rs_used=1 → one cycle with en_pc=0, en_ifid=0, nop_idex=1; the next cycle is normal.
- Same as above but id_rs_used=0 and id_rt=5 → no stall; all enables 1.
- br_taken=1 together with a load-use match → flush_ifid=1, nop_idex=1, en_pc=1; no freeze.
- dmem_stall held 3 cycles, then dmem_done → 3 cycles with en_exmem=0 and nop_memwb=1; the 4th cycle has all enables 1; stall_cnt=3.
- dmem_stall held without dmem_done for 64 cycles (MAX_WAIT=64) → err=1, halted=1, all enables 0; rst clears both flags.
- halt_wb=1 → en_memwb=1 in that cycle only, then halted=1 and all enables 0 permanently; assert rst mid-HALT → outputs return to their reset values immediately (asynchronous).
